// File: rtl/param_sram.sv
// ---------------------------------------------------------------------------
// param_sram
//   Single-port, byte-writable synchronous SRAM with a self-zeroing sweep.
//   After reset release, and after every accepted clear, the array is swept
//   from address 0 to DEPTH-1, writing one zero word per cycle. No requests
//   are accepted during the sweep. Reads have a latency of one cycle and
//   produce a one-cycle rsp_valid pulse. Writes produce no response.
//
// Parameters
//   DATA_W  word width in bits (multiple of 8)
//   ADDR_W  address width; DEPTH = 2**ADDR_W words
//   BE_W    byte-enable width, DATA_W/8 (derived)
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   clear      in   request to re-zero the whole array (honoured only in READY)
//   req_valid  in   request presented
//   req_ready  out  request can be accepted this cycle (combinational)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   req_be     in   byte enables, bit i covers bits [8i+7:8i]
//   rsp_valid  out  read data valid, one pulse per accepted read
//   rsp_rdata  out  registered read data, holds when rsp_valid = 0
//   init_busy  out  array is being zeroed
// ---------------------------------------------------------------------------
module param_sram #(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned ADDR_W = 11,
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_init_cnt;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;

  // Storage array: deliberately not reset; it is defined by the zero sweep.
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic                w_rd_accept;
  logic                w_wr_accept;
  logic                w_init_we;

  assign req_ready   = (r_state == READY) && !clear;
  assign w_accept    = req_valid && req_ready;
  assign w_rd_accept = w_accept && !req_we;
  assign w_wr_accept = w_accept && req_we;

  // The sweep write is gated by reset so that clocks arriving while reset
  // is held do not touch the array.
  assign w_init_we   = (r_state == INIT) && reset;

  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign init_busy   = (r_state == INIT);

  // Control FSM, sweep counter and read response register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= INIT;
      r_init_cnt  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_rsp_rdata <= r_mem[req_addr];
      end

      unique case (r_state)
        INIT: begin
          // Counter wraps to 0 on the final write, ready for the next sweep.
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == '1) begin
            r_state <= READY;
          end
        end
        READY: begin
          if (clear) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
          end
        end
        default: begin
          r_state    <= INIT;
          r_init_cnt <= '0;
        end
      endcase
    end
  end

  // Array write port: sweep zeroing has priority; requests are never
  // accepted during INIT, so the two never collide.
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_mem[r_init_cnt] <= '0;
    end else if (w_wr_accept) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (req_be[i]) begin
          r_mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/param_sram.md
PARAM_SRAM -- requirements
Module: param_sram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning word width in bits; it must be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 11, meaning address width; DEPTH = 2**ADDR_W words (2048 by default).
REQ-003 The block SHALL have derived parameter BE_W, equal to DATA_W/8, meaning byte-enable width.
REQ-004 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: clear  in  1  request to re-zero the whole array.
REQ-007 Port: req_valid  in  1  a request is presented.
REQ-008 Port: req_ready  out  1  the block can accept a request this cycle.
REQ-009 Port: req_we  in  1  1 = write, 0 = read.
REQ-010 Port: req_addr  in  ADDR_W  word address.
REQ-011 Port: req_wdata  in  DATA_W  write data.
REQ-012 Port: req_be  in  BE_W  byte enables; bit i covers bits [8i+7:8i].
REQ-013 Port: rsp_valid  out  1  read data valid, one-cycle pulse per accepted read.
REQ-014 Port: rsp_rdata  out  DATA_W  read data, registered.
REQ-015 Port: init_busy  out  1  the array is being zeroed.

Function
REQ-016 The block SHALL implement an FSM with exactly two states, INIT and READY.
REQ-017 In INIT, the block SHALL write zero to array[init_cnt] every cycle, then increment init_cnt.
REQ-018 When init_cnt = DEPTH-1, the block SHALL perform that final write and go to READY on the same edge, so INIT lasts exactly DEPTH cycles.
REQ-019 init_busy SHALL be 1 exactly while in INIT.
REQ-020 req_ready SHALL equal (state==READY) && !clear, and SHALL be combinational.
REQ-021 A request SHALL be accepted on any rising edge where req_valid && req_ready; otherwise the request is ignored and has no side effects.
REQ-022 An accepted write SHALL update only the bytes whose req_be bit is 1; req_be = 0 SHALL be a legal no-op write.
REQ-023 An accepted write SHALL NOT produce a response.
REQ-024 An accepted read at edge N SHALL drive rsp_valid = 1 and rsp_rdata = array[req_addr] for the cycle following edge N; the read latency is 1.
REQ-025 rsp_valid SHALL return to 0 on the next edge unless another read is accepted; back-to-back reads SHALL give back-to-back responses.
REQ-026 rsp_rdata SHALL hold its last value when rsp_valid = 0.
REQ-027 There SHALL be no response backpressure.
REQ-028 A read accepted on the edge after a write to the same address SHALL return the newly written bytes.
REQ-029 clear = 1 in READY SHALL move the FSM to INIT with init_cnt = 0 on the next edge, and no request SHALL be accepted in that cycle.
REQ-030 A read accepted on the edge before clear SHALL still deliver its response.
REQ-031 clear SHALL be ignored while in INIT; the sweep SHALL NOT restart.
REQ-032 The array SHALL NOT be reset directly; its contents SHALL be defined only after the first INIT sweep completes.

Reset
REQ-033 While reset = 0, the FSM SHALL be in INIT, init_cnt = 0, rsp_valid = 0, rsp_rdata = 0, init_busy = 1 and req_ready = 0.
REQ-034 On reset release, the INIT sweep SHALL start from address 0.
REQ-035 Reset asserted mid-INIT or mid-READY SHALL abort all activity immediately and restart the full sweep after release.

Verification
REQ-036 Reset release, defaults: init_busy = 1 and req_ready = 0 for exactly 2048 cycles, then req_ready = 1; a read of any address returns 0x00.
REQ-037 Write addr 0x7FF data 0xA5, then read 0x7FF on the next cycle: rsp_valid is 1 one cycle after acceptance with rsp_rdata = 0xA5.
REQ-038 DATA_W = 32: write 0x11223344 with be = 4'b1111, then 0xAABBCCDD with be = 4'b0101; a read returns 0x11BB33DD.
REQ-039 Back-to-back reads of addresses 1, 2, 3 holding 0x01, 0x02, 0x03: rsp_valid is high 3 consecutive cycles with 0x01, 0x02, 0x03; a req_valid held while req_ready = 0 causes no write.
REQ-040 Read accepted, then clear asserted the next cycle: the response is still delivered, init_busy rises, and after 2048 cycles previously written addresses read 0x00.
REQ-041 Reset pulsed at init_cnt = 1000: after release, INIT lasts a full 2048 cycles; clear asserted during INIT does not extend it.
